// File: rtl/bldc_hall_tracker.sv
// Hall-sensor position tracker: sync + glitch filter, signed step count with snapshot/clear,
// direction, saturating error count. Define BLDC_HALL_PERIOD_EN for commutation period / stall timing.
module bldc_hall_tracker #(
  parameter int COUNTER_WIDTH = 16,
  parameter int FILTER_DEPTH  = 4,
  parameter int ERR_WIDTH     = 8,
  parameter int PERIOD_WIDTH  = 20
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [2:0]               hall,
  input  logic                     sample,
  input  logic                     err_clear,
  output logic [COUNTER_WIDTH-1:0] count,
  output logic [COUNTER_WIDTH-1:0] count_latched,
  output logic                     dir,
  output logic [ERR_WIDTH-1:0]     err_count,
  output logic [PERIOD_WIDTH-1:0]  period,
  output logic                     stalled
);

  localparam int FW = (FILTER_DEPTH < 1) ? 1 : $clog2(FILTER_DEPTH + 1);
  localparam logic [FW-1:0] FDEPTH = FW'(FILTER_DEPTH);
  localparam logic signed [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

  function automatic logic is_valid(input logic [2:0] h);
    return (h != 3'b000) && (h != 3'b111);
  endfunction

  // Successor of h in the forward sequence 101-100-110-010-011-001.
  function automatic logic [2:0] fwd_next(input logic [2:0] h);
    logic [2:0] n;
    case (h)
      3'b101:  n = 3'b100;
      3'b100:  n = 3'b110;
      3'b110:  n = 3'b010;
      3'b010:  n = 3'b011;
      3'b011:  n = 3'b001;
      3'b001:  n = 3'b101;
      default: n = 3'b000;
    endcase
    return n;
  endfunction

  function automatic logic [ERR_WIDTH-1:0] err_sat_inc(input logic [ERR_WIDTH-1:0] v);
    return (&v) ? v : v + ERR_WIDTH'(1);
  endfunction

  logic [2:0]                      hall_meta, hall_s;
  logic [2:0]                      cand, cand_nxt;
  logic [FW-1:0]                   fcnt, fcnt_nxt;
  logic [2:0]                      hall_f, hall_f_nxt, hall_f_d;
  logic                            primed;
  logic                            changed, new_valid, old_valid;
  logic                            step_fwd, step_rev, err, prime_set;
  logic signed [COUNTER_WIDTH-1:0] count_r, count_step;

  // Stage: two-flop synchroniser
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hall_meta <= '0;
      hall_s    <= '0;
    end else begin
      hall_meta <= hall;
      hall_s    <= hall_meta;
    end
  end

  // hall_f updates on the same edge the stability count reaches FILTER_DEPTH.
  always_comb begin
    cand_nxt = cand;
    fcnt_nxt = fcnt;
    if (hall_s != cand) begin
      cand_nxt = hall_s;
      fcnt_nxt = FW'(1);
    end else if (fcnt != FDEPTH) begin
      fcnt_nxt = fcnt + FW'(1);
    end
    hall_f_nxt = (fcnt_nxt == FDEPTH) ? cand_nxt : hall_f;
  end

  // Stage: glitch filter and edge-detect delay
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand     <= '0;
      fcnt     <= '0;
      hall_f   <= '0;
      hall_f_d <= '0;
    end else begin
      cand     <= cand_nxt;
      fcnt     <= fcnt_nxt;
      hall_f   <= hall_f_nxt;
      hall_f_d <= hall_f;
    end
  end

  // Leaving an invalid state is silent: the error was charged on entry.
  always_comb begin
    changed   = (hall_f != hall_f_d);
    new_valid = is_valid(hall_f);
    old_valid = is_valid(hall_f_d);
    prime_set = !primed && new_valid;
    step_fwd  = primed && changed && new_valid && old_valid && (fwd_next(hall_f_d) == hall_f);
    step_rev  = primed && changed && new_valid && old_valid && (fwd_next(hall_f) == hall_f_d);
    err       = primed && changed && (!new_valid || (old_valid && !step_fwd && !step_rev));
    count_step = count_r;
    if (step_fwd)      count_step = count_r + ONE;
    else if (step_rev) count_step = count_r - ONE;
  end

  // Stage: count, direction and error registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      primed        <= 1'b0;
      count_r       <= '0;
      count_latched <= '0;
      dir           <= 1'b0;
      err_count     <= '0;
    end else begin
      if (prime_set) primed <= 1'b1;
      if (sample) begin
        count_latched <= count_step;
        count_r       <= '0;
      end else begin
        count_r       <= count_step;
      end
      if (step_fwd)      dir <= 1'b1;
      else if (step_rev) dir <= 1'b0;
      if (err_clear)     err_count <= err ? ERR_WIDTH'(1) : '0;
      else if (err)      err_count <= err_sat_inc(err_count);
    end
  end

  assign count = count_r;

`ifdef BLDC_HALL_PERIOD_EN
  function automatic logic [PERIOD_WIDTH-1:0] per_sat_inc(input logic [PERIOD_WIDTH-1:0] v);
    return (&v) ? v : v + PERIOD_WIDTH'(1);
  endfunction

  logic [PERIOD_WIDTH-1:0] timer, timer_inc, period_r;
  logic                    stalled_r;

  assign timer_inc = per_sat_inc(timer);

  // Stage: commutation period timer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer     <= '0;
      period_r  <= '0;
      stalled_r <= 1'b0;
    end else if (step_fwd || step_rev) begin
      period_r  <= timer_inc;
      timer     <= '0;
      stalled_r <= 1'b0;
    end else begin
      timer <= timer_inc;
      if (&timer_inc) begin
        stalled_r <= 1'b1;
        period_r  <= '1;
      end
    end
  end

  assign period  = period_r;
  assign stalled = stalled_r;
`else
  assign period  = '0;
  assign stalled = 1'b0;
`endif

endmodule

// File: tb/tb_bldc_hall_tracker.sv
// Directed bench for bldc_hall_tracker (FILTER_DEPTH=4, COUNTER_WIDTH=16, ERR_WIDTH=8, PERIOD_WIDTH=8).
module tb_bldc_hall_tracker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  hall;
  logic        sample;
  logic        err_clear;
  logic [15:0] count;
  logic [15:0] count_latched;
  logic        dir;
  logic [7:0]  err_count;
  logic [7:0]  period;
  logic        stalled;

  int n_assert = 0;
  int n_fail   = 0;

  logic [2:0] fseq [6];

  bldc_hall_tracker #(
    .COUNTER_WIDTH(16), .FILTER_DEPTH(4), .ERR_WIDTH(8), .PERIOD_WIDTH(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hall(hall), .sample(sample), .err_clear(err_clear),
    .count(count), .count_latched(count_latched), .dir(dir), .err_count(err_count),
    .period(period), .stalled(stalled)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [2:0] v, input int n);
    hall = v;
    tick(n);
  endtask

  task automatic pulse_sample();
    sample = 1'b1;
    tick(1);
    sample = 1'b0;
  endtask

  initial begin
    fseq[0] = 3'b100; fseq[1] = 3'b110; fseq[2] = 3'b010;
    fseq[3] = 3'b011; fseq[4] = 3'b001; fseq[5] = 3'b101;
    reset_n = 1'b0; hall = 3'b101; sample = 1'b0; err_clear = 1'b0;
    tick(3);
    chk("rst_count", count, 0);
    chk("rst_latched", count_latched, 0);
    chk("rst_dir", dir, 0);
    chk("rst_err", err_count, 0);
    chk("rst_period", period, 0);
    chk("rst_stalled", stalled, 0);

    reset_n = 1'b1;
    tick(12);
    chk("prime_no_count", count, 0);
    chk("prime_no_err", err_count, 0);

    // forward: first step visible 7 cycles after the input change
    hall = fseq[0];
    tick(6);
    chk("fwd_latency_pre", count, 0);
    tick(1);
    chk("fwd_latency", count, 1);
    tick(3);
    for (int i = 1; i < 12; i++) hold(fseq[i % 6], 10);
    chk("fwd_count12", count, 12);
    chk("fwd_dir", dir, 1);
    chk("fwd_err", err_count, 0);
    pulse_sample();
    chk("sample_latched", count_latched, 12);
    chk("sample_clear", count, 0);

    // glitch rejection at 101
    hold(3'b100, 3);
    hold(3'b101, 12);
    chk("glitch3_rejected", count, 0);
    hold(3'b100, 4);
    hold(3'b101, 3);
    chk("glitch4_accepted", count, 1);
    tick(10);
    chk("glitch4_return", count, 0);
    chk("glitch4_return_dir", dir, 0);

    // move to 011, clear, then three reverse steps ending at 100
    for (int i = 0; i < 4; i++) hold(fseq[i], 10);
    pulse_sample();
    chk("pre_rev_latched", count_latched, 4);
    chk("pre_rev_count", count, 0);
    hold(3'b010, 10);
    hold(3'b110, 10);
    hold(3'b100, 10);
    chk("rev_wrap", count, 16'hFFFD);
    chk("rev_dir", dir, 0);
    hold(3'b111, 10);
    chk("inv_enter_err", err_count, 1);
    chk("inv_enter_count", count, 16'hFFFD);
    hold(3'b110, 10);
    chk("inv_exit_err", err_count, 1);
    chk("inv_exit_count", count, 16'hFFFD);
    hold(3'b011, 10);
    chk("skip_err", err_count, 2);
    chk("skip_count", count, 16'hFFFD);
    pulse_sample();
    chk("neg_latched", count_latched, 16'hFFFD);

    // sample coincident with a forward step
    for (int i = 4; i < 9; i++) hold(fseq[i % 6], 10);
    chk("coll_pre", count, 5);
    hall = 3'b011;
    tick(6);
    sample = 1'b1;
    tick(1);
    sample = 1'b0;
    chk("coll_latched", count_latched, 6);
    chk("coll_count", count, 0);
    tick(5);
    chk("coll_no_double", count, 0);
    chk("coll_dir", dir, 1);

    // err_clear coincident with an error, then alone
    hall = 3'b111;
    tick(6);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    chk("errclr_coll", err_count, 1);
    hold(3'b011, 10);
    chk("errclr_hold", err_count, 1);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    chk("errclr_alone", err_count, 0);

    // error counter saturation
    for (int i = 0; i < 260; i++) begin
      hold(3'b111, 8);
      hold(3'b011, 8);
    end
    chk("err_sat", err_count, 255);
    chk("err_sat_count", count, 0);

    // reset mid-run at count 9
    for (int i = 4; i < 13; i++) hold(fseq[i % 6], 10);
    chk("mid_count9", count, 9);
    reset_n = 1'b0;
    #2;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_latched", count_latched, 0);
    chk("mid_rst_dir", dir, 0);
    chk("mid_rst_err", err_count, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick(12);
    chk("reprime_count", count, 0);
    chk("reprime_err", err_count, 0);
    hold(3'b110, 10);
    chk("reprime_step", count, 1);
    chk("reprime_dir", dir, 1);

`ifdef BLDC_HALL_PERIOD_EN
    hold(3'b010, 100);
    hold(3'b011, 100);
    hold(3'b001, 100);
    chk("period100", period, 100);
    chk("period_not_stalled", stalled, 0);
    tick(150);
    chk("stall_pre", stalled, 0);
    tick(20);
    chk("stall_set", stalled, 1);
    chk("stall_period", period, 255);
    hold(3'b101, 10);
    chk("stall_clear", stalled, 0);
    chk("stall_count", count, 5);
`else
    chk("period_tied", period, 0);
    chk("stalled_tied", stalled, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bldc_hall_tracker.md
Name: bldc_hall_tracker

Overview:
- Successor to the BLDC hall counter for one motor.
- Adds input synchronisation and a glitch filter on the raw hall lines.
- Keeps a signed, parametrised position count, with snapshot-and-clear for the control loop.
- Adds direction tracking, an invalid-transition error counter and, optionally, commutation-period and stall measurement.
- Sits between the hall input pins and the motor-control register file.

Parameters:
- COUNTER_WIDTH, 16: width of count and count_latched (two's complement).
- FILTER_DEPTH, 4: consecutive identical synchronised samples required before a hall change is accepted; minimum 1.
- ERR_WIDTH, 8: width of the saturating error counter.
- PERIOD_WIDTH, 20: width of the period timer and period output.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- hall  input  3  raw hall sensor lines, asynchronous to clk
- sample  input  1  one-cycle pulse: snapshot count into count_latched and clear count
- err_clear  input  1  one-cycle pulse: clear err_count
- count  output  COUNTER_WIDTH  running signed step count since last sample
- count_latched  output  COUNTER_WIDTH  snapshot taken at last sample
- dir  output  1  direction of last valid step: 1 = forward (+1), 0 = reverse
- err_count  output  ERR_WIDTH  saturating count of invalid transitions
- period  output  PERIOD_WIDTH  clk cycles between the last two valid steps
- stalled  output  1  no valid step for 2^PERIOD_WIDTH-1 cycles

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0; sync flops, filter, primed flag and timer are 0.
- Synchroniser: two flops on hall, giving hall_s.
- Filter: a candidate register plus a stability counter.
  - hall_s differs from candidate: candidate <= hall_s, counter <= 1.
  - Otherwise the counter increments, saturating at FILTER_DEPTH.
  - When the counter reaches FILTER_DEPTH, hall_f <= candidate.
  - Clean input-to-hall_f latency is 2+FILTER_DEPTH cycles.
  - Pulses shorter than FILTER_DEPTH cycles never reach hall_f.
- Forward sequence: 101 -> 100 -> 110 -> 010 -> 011 -> 001 -> 101.
- Classification of a change (hall_f_d != hall_f, where hall_f_d is hall_f delayed one cycle); classification logic is combinational:
  - Forward neighbour: step = +1, dir <= 1.
  - Reverse neighbour: step = -1, dir <= 0.
  - New value is 000 or 111: error; no step. No further error is raised for the exit from that invalid state.
  - Valid to valid non-neighbour (skipped state): error; no step.
- Priming: after reset, the first valid hall_f value only sets the primed flag. No step and no error is produced until primed.
- Count update: count <= count + step, modulo 2^COUNTER_WIDTH (wraps, e.g. 0 - 1 = all ones). The result is registered: count reflects a hall_f change 1 cycle later.
- Sample in the same cycle as a step:
  - count_latched <= count + step.
  - count <= 0.
  - No step is lost or double-counted.
- err_count: increments on each error and saturates at 2^ERR_WIDTH-1.
  - err_clear alone sets err_count to 0.
  - err_clear together with an error sets err_count to 1.
- dir holds its value when there is no step.
- Reset asserted mid-operation clears everything immediately. After release the block re-primes and ignores the first valid state.

Optional Feature:
- Macro: BLDC_HALL_PERIOD_EN.
- Defined:
  - timer increments every cycle, saturating at all ones.
  - On a valid step: period <= timer+1 (saturated), timer <= 0, stalled <= 0.
  - When timer reaches all ones: stalled <= 1 and period <= all ones.
  - The first step after priming also loads period.
  - Errors do not affect the timer.
- Undefined: the timer logic is not synthesised; period and stalled are tied to 0.

Test Plan:
- Forward sequence: 12 forward steps from 101, each held 10 cycles (FILTER_DEPTH=4) -> count=12, dir=1, err_count=0; first step appears at count 7 cycles after the first change (2 sync + 4 filter + 1 register).
- Glitch rejection: hall at 101 (primed), 3-cycle pulse to 100 -> count stays 0. Same pulse for 4 cycles -> count=1.
- Reverse and wrap: from count=0, three reverse steps -> count=0xFFFD, dir=0. Then 100 -> 111 -> 110 -> err_count=1, count unchanged. Skip 110 -> 011 -> err_count=2.
- Sample collision: count=5 and sample coincident with a forward step -> count_latched=6, count=0 next cycle. err_clear coincident with an error -> err_count=1.
- Reset mid-run: reset_n low for 1 cycle at count=9 -> all outputs 0 at once. The first valid state after release gives no count.
- Period (BLDC_HALL_PERIOD_EN, PERIOD_WIDTH=8): forward steps every 100 cycles -> period=100. Hold hall constant 255 cycles -> stalled=1, period=255. Next step -> stalled=0.
